// File: rtl/fixed_point_pkg.sv
// Shared encodings and Q-format helpers for the fixed-point adder stimulus path.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO    = 2'b00,
        MODE_RAMP    = 2'b01,
        MODE_SQUARE  = 2'b10,
        MODE_IMPULSE = 2'b11
    } mode_e;

    typedef enum logic {
        SQ_POS = 1'b0,
        SQ_NEG = 1'b1
    } sq_phase_e;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int Q_FRAC_BITS        = DEFAULT_DATA_WIDTH - 1;

    // Largest positive and most negative two's-complement values for a given width.
    function automatic logic [31:0] pos_max(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] neg_max(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_point_stimulus_gen_tick_prescaler.sv
// Free-running sample-rate divider; freezes while disabled, restarts on clear.
module tick_prescaler #(
    parameter int TICK_DIV = 2700000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tick = i_enable && (count_q == LAST);

endmodule

// File: rtl/fixed_point_stimulus_gen.sv
// Q1.(DATA_WIDTH-1) test-pattern source: zero, ramp, square or impulse, one sample per tick.
module fixed_point_stimulus_gen
    import fixed_point_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TICK_DIV   = 2700000,
    parameter int RAMP_STEP  = 1,
    parameter int SQ_HALF    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [1:0]            i_mode,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    localparam logic [DATA_WIDTH-1:0] POS_MAX = DATA_WIDTH'(pos_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] NEG_MAX = DATA_WIDTH'(neg_max(DATA_WIDTH));
    localparam int SW = $clog2(SQ_HALF + 1);
    localparam logic [SW-1:0] SQ_LAST = SW'(SQ_HALF - 1);

    mode_e                 mode_q, mode_d;
    logic                  en_q, en_d;
    logic [DATA_WIDTH-1:0] ramp_acc_q, ramp_acc_d;
    logic [SW-1:0]         sq_cnt_q, sq_cnt_d;
    sq_phase_e             sq_phase_q, sq_phase_d;
    logic                  imp_armed_q, imp_armed_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    logic tick;
    logic mode_change;
    logic en_rise;

    assign mode_change = (mode_e'(i_mode) != mode_q);
    assign en_rise     = i_enable && !en_q;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (i_enable),
        .i_clear   (mode_change),
        .o_tick    (tick)
    );

    // A mode change wins over a coincident tick so the new pattern starts cleanly.
    always_comb begin
        mode_d      = mode_e'(i_mode);
        en_d        = i_enable;
        ramp_acc_d  = ramp_acc_q;
        sq_cnt_d    = sq_cnt_q;
        sq_phase_d  = sq_phase_q;
        imp_armed_d = imp_armed_q;
        data_d      = data_q;
        valid_d     = 1'b0;

        if (mode_change) begin
            ramp_acc_d  = '0;
            sq_cnt_d    = '0;
            sq_phase_d  = SQ_POS;
            imp_armed_d = 1'b1;
            data_d      = '0;
        end else begin
            if (en_rise) begin
                imp_armed_d = 1'b1;
            end
            if (tick) begin
                valid_d = 1'b1;
                case (mode_q)
                    MODE_RAMP: begin
                        ramp_acc_d = ramp_acc_q + DATA_WIDTH'(RAMP_STEP);
                        data_d     = ramp_acc_d;
                    end
                    MODE_SQUARE: begin
                        data_d = (sq_phase_q == SQ_POS) ? POS_MAX : NEG_MAX;
                        if (sq_cnt_q == SQ_LAST) begin
                            sq_cnt_d   = '0;
                            sq_phase_d = (sq_phase_q == SQ_POS) ? SQ_NEG : SQ_POS;
                        end else begin
                            sq_cnt_d = sq_cnt_q + SW'(1);
                        end
                    end
                    MODE_IMPULSE: begin
                        if (imp_armed_q || en_rise) begin
                            data_d      = POS_MAX;
                            imp_armed_d = 1'b0;
                        end else begin
                            data_d = '0;
                        end
                    end
                    default: begin
                        data_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_q      <= MODE_ZERO;
            en_q        <= 1'b0;
            ramp_acc_q  <= '0;
            sq_cnt_q    <= '0;
            sq_phase_q  <= SQ_POS;
            imp_armed_q <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            en_q        <= en_d;
            ramp_acc_q  <= ramp_acc_d;
            sq_cnt_q    <= sq_cnt_d;
            sq_phase_q  <= sq_phase_d;
            imp_armed_q <= imp_armed_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_fixed_point_stimulus_gen.sv
// Directed bench for fixed_point_stimulus_gen with TICK_DIV=4, SQ_HALF=2, RAMP_STEP=1.
module tb_fixed_point_stimulus_gen;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_enable;
    logic [1:0] i_mode;
    logic [7:0] o_data;
    logic       o_valid;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        int         gap;
    } vec_t;

    vec_t vecs[13];

    fixed_point_stimulus_gen #(
        .DATA_WIDTH (8),
        .TICK_DIV   (4),
        .RAMP_STEP  (1),
        .SQ_HALF    (2)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (i_enable),
        .i_mode    (i_mode),
        .o_data    (o_data),
        .o_valid   (o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Counts falling edges until o_valid is seen; a missing strobe is reported as a failure.
    task automatic wait_sample(output int cycles);
        cycles = 0;
        do begin
            @(negedge i_clk);
            cycles++;
        end while (!o_valid && cycles < 40);
        if (!o_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL sample_timeout: got no o_valid, expected one within 40 cycles");
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] mode, input logic en);
        i_mode   = mode;
        i_enable = en;
    endtask

    initial begin
        int  gap;
        logic bad;

        vecs[0]  = '{2'b01, 8'h01, 5};
        vecs[1]  = '{2'b01, 8'h02, 4};
        vecs[2]  = '{2'b01, 8'h03, 4};
        vecs[3]  = '{2'b10, 8'h7F, 5};
        vecs[4]  = '{2'b10, 8'h7F, 4};
        vecs[5]  = '{2'b10, 8'h80, 4};
        vecs[6]  = '{2'b10, 8'h80, 4};
        vecs[7]  = '{2'b10, 8'h7F, 4};
        vecs[8]  = '{2'b11, 8'h7F, 5};
        vecs[9]  = '{2'b11, 8'h00, 4};
        vecs[10] = '{2'b11, 8'h00, 4};
        vecs[11] = '{2'b00, 8'h00, 5};
        vecs[12] = '{2'b00, 8'h00, 4};

        checks    = 0;
        errors    = 0;
        i_reset_n = 1'b0;
        apply_stimulus(2'b00, 1'b0);
        repeat (2) @(negedge i_clk);
        check_output("reset_data", {24'd0, o_data}, 32'h00);
        check_output("reset_valid", {31'd0, o_valid}, 32'h0);
        i_reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].mode, 1'b1);
            wait_sample(gap);
            check_output($sformatf("vec%0d_data", i), {24'd0, o_data}, {24'd0, vecs[i].data});
            check_output($sformatf("vec%0d_gap", i), gap, vecs[i].gap);
        end

        // Impulse re-arms on an enable rising edge.
        apply_stimulus(2'b11, 1'b1);
        wait_sample(gap);
        check_output("imp_first", {24'd0, o_data}, 32'h7F);
        wait_sample(gap);
        check_output("imp_second", {24'd0, o_data}, 32'h00);
        apply_stimulus(2'b11, 1'b0);
        bad = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_valid) bad = 1'b1;
        end
        check_output("imp_disabled_valid", {31'd0, bad}, 32'h0);
        apply_stimulus(2'b11, 1'b1);
        wait_sample(gap);
        check_output("imp_rearm_data", {24'd0, o_data}, 32'h7F);
        check_output("imp_rearm_gap", gap, 4);

        // Freeze in ramp mode with the prescaler part-way through a period.
        apply_stimulus(2'b01, 1'b1);
        wait_sample(gap);
        check_output("frz_r1", {24'd0, o_data}, 32'h01);
        wait_sample(gap);
        check_output("frz_r2", {24'd0, o_data}, 32'h02);
        repeat (2) @(negedge i_clk);
        apply_stimulus(2'b01, 1'b0);
        bad = 1'b0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_valid || o_data !== 8'h02) bad = 1'b1;
        end
        check_output("frz_hold", {31'd0, bad}, 32'h0);
        apply_stimulus(2'b01, 1'b1);
        wait_sample(gap);
        check_output("frz_resume_data", {24'd0, o_data}, 32'h03);
        check_output("frz_resume_gap", gap, 2);

        // Run the ramp up to the signed wrap point.
        bad = 1'b0;
        for (int v = 4; v <= 126; v++) begin
            wait_sample(gap);
            if (o_data !== 8'(v) || gap != 4) bad = 1'b1;
        end
        check_output("ramp_run", {31'd0, bad}, 32'h0);
        wait_sample(gap);
        check_output("ramp_pos_max", {24'd0, o_data}, 32'h7F);
        wait_sample(gap);
        check_output("ramp_wrap", {24'd0, o_data}, 32'h80);

        // Mode change landing exactly on the tick edge.
        repeat (3) @(negedge i_clk);
        apply_stimulus(2'b10, 1'b1);
        @(negedge i_clk);
        check_output("mc_valid", {31'd0, o_valid}, 32'h0);
        check_output("mc_data", {24'd0, o_data}, 32'h00);
        wait_sample(gap);
        check_output("mc_sq_data", {24'd0, o_data}, 32'h7F);
        check_output("mc_sq_gap", gap, 4);

        // Asynchronous reset between clock edges.
        #2;
        i_reset_n = 1'b0;
        #1;
        check_output("async_rst_data", {24'd0, o_data}, 32'h00);
        check_output("async_rst_valid", {31'd0, o_valid}, 32'h0);
        @(negedge i_clk);
        apply_stimulus(2'b00, 1'b1);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        wait_sample(gap);
        check_output("post_rst_gap", gap, 4);
        check_output("post_rst_data", {24'd0, o_data}, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
